// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } sched_state_t;

    // Number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin index selector: first valid requester at or after rr_ptr, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic [SEL_W-1:0]   sel,
    output logic               any
);

    localparam int unsigned N_U = NUM_REQ;

    logic [31:0] idx;

    // Walk the requesters starting at the pointer; keep the first hit.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            idx = (32'(rr_ptr) + i) % N_U;
            if (!any && req_valid[idx[SEL_W-1:0]]) begin
                any = 1'b1;
                sel = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Optional packet lock: define UART_SCHED_PKT_LOCK_EN to keep the grant on a
// requester until it completes a byte flagged with req_last.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  GAP_CYCLES = 0,
    localparam int SEL_W      = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                      MAX10_CLK1_50,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_dv,
    output logic [BYTE_W-1:0]         tx_byte,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [SEL_W-1:0]          grant_id
);

`ifdef UART_SCHED_PKT_LOCK_EN
    localparam bit PKT_LOCK = 1'b1;
`else
    localparam bit PKT_LOCK = 1'b0;
`endif

    localparam int unsigned N_U = NUM_REQ;

    sched_state_t        state, state_n;
    logic [SEL_W-1:0]    rr_ptr, rr_ptr_n;
    logic [7:0]          gap_cnt, gap_cnt_n;
    logic                locked, locked_n;
    logic                last_q, last_n;
    logic [NUM_REQ-1:0]  ready_n;
    logic                dv_n;
    logic [BYTE_W-1:0]   byte_n;
    logic [SEL_W-1:0]    grant_n;

    logic [SEL_W-1:0]    rr_sel;
    logic                rr_any;
    logic [SEL_W-1:0]    pick_sel;
    logic                pick_any;
    logic [BYTE_W-1:0]   pick_byte;
    logic [SEL_W-1:0]    next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .sel       (rr_sel),
        .any       (rr_any)
    );

    assign busy     = (state != IDLE);
    assign next_ptr = (grant_id == SEL_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Candidate selection: a locked packet restricts the choice to its owner.
    always_comb begin
        pick_sel  = rr_sel;
        pick_any  = rr_any;
        pick_byte = '0;
        if (locked) begin
            pick_sel = grant_id;
            pick_any = req_valid[grant_id];
        end
        for (int unsigned i = 0; i < N_U; i++) begin
            if (SEL_W'(i) == pick_sel) begin
                pick_byte = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        gap_cnt_n = gap_cnt;
        locked_n  = locked;
        last_n    = last_q;
        ready_n   = '0;
        dv_n      = 1'b0;
        byte_n    = tx_byte;
        grant_n   = grant_id;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n           = pick_sel;
                    byte_n            = pick_byte;
                    last_n            = req_last[pick_sel];
                    ready_n[pick_sel] = 1'b1;
                    state_n           = ISSUE;
                end
            end
            ISSUE: begin
                dv_n    = 1'b1;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (PKT_LOCK && !last_q) begin
                        rr_ptr_n = grant_id;
                        locked_n = 1'b1;
                    end else begin
                        rr_ptr_n = next_ptr;
                        locked_n = 1'b0;
                    end
                    if (GAP_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        gap_cnt_n = 8'(GAP_CYCLES - 1);
                        state_n   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gap_cnt   <= '0;
            locked    <= 1'b0;
            last_q    <= 1'b0;
            req_ready <= '0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
            grant_id  <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            gap_cnt   <= gap_cnt_n;
            locked    <= locked_n;
            last_q    <= last_n;
            req_ready <= ready_n;
            tx_dv     <= dv_n;
            tx_byte   <= byte_n;
            grant_id  <= grant_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (GAP_CYCLES=0 and =5 instances).
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_dv, tx_done, busy;
    logic [7:0]  tx_byte;
    logic [1:0]  grant_id;

    logic [3:0]  req_valid_g, req_last_g, req_ready_g;
    logic [31:0] req_data_g;
    logic        tx_dv_g, tx_done_g, busy_g;
    logic [7:0]  tx_byte_g;
    logic [1:0]  grant_id_g;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0)) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_dv         (tx_dv),
        .tx_byte       (tx_byte),
        .tx_done       (tx_done),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(5)) dut_gap (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .req_valid     (req_valid_g),
        .req_data      (req_data_g),
        .req_last      (req_last_g),
        .req_ready     (req_ready_g),
        .tx_dv         (tx_dv_g),
        .tx_byte       (tx_byte_g),
        .tx_done       (tx_done_g),
        .busy          (busy_g),
        .grant_id      (grant_id_g)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance until tx_dv is seen, bounded.
    task automatic wait_dv(input string tag);
        int n;
        n = 0;
        while (tx_dv !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_dv_seen"}, 32'(tx_dv), 1);
    endtask

    // Model of uart_tx: hold the frame for 'hold' clocks, then pulse tx_done.
    task automatic serve(input int hold, input logic [7:0] exp, input string tag);
        int extra;
        extra = 0;
        repeat (hold) begin
            tick();
            if (tx_dv) extra++;
        end
        check({tag, "_extra_dv"}, extra, 0);
        check({tag, "_hold"}, 32'(tx_byte), 32'(exp));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    logic [7:0] exp_b [4];
    logic [1:0] exp_g [4];
    int cnt0;
    int first_idle;
    int dv_at;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; tx_done = 1'b0;
        req_valid_g = '0; req_last_g = '0; req_data_g = '0; tx_done_g = 1'b0;
        tick();
        tick();
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        rst = 1'b0;
        tick();

        // Round-robin with all requesters valid.
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_dv("rr");
            check("rr_byte", 32'(tx_byte), 32'h10 + 32'(k % 4));
            check("rr_grant", 32'(grant_id), 32'(k % 4));
            if (k == 4) req_valid = '0;
            serve(20, 8'(8'h10 + k % 4), "rr");
        end

        // Single requester (pointer is at 1, request on 2).
        req_data  = '0;
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        tick();
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_grant", 32'(grant_id), 2);
        check("single_byte", 32'(tx_byte), 32'hA5);
        check("single_busy", 32'(busy), 1);
        check("single_dv_early", 32'(tx_dv), 0);
        req_valid = '0;
        req_data  = '0;
        tick();
        check("single_dv", 32'(tx_dv), 1);
        check("single_byte_dv", 32'(tx_byte), 32'hA5);
        check("single_ready_off", 32'(req_ready), 0);
        serve(5, 8'hA5, "single");
        check("single_idle", 32'(busy), 0);
        check("single_grant_kept", 32'(grant_id), 2);

        // Collision: new request in the tx_done cycle.
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        wait_dv("col1");
        check("col1_grant", 32'(grant_id), 0);
        check("col1_byte", 32'(tx_byte), 32'h55);
        req_valid = '0;
        repeat (4) tick();
        req_valid = 4'b0010;
        req_data[15:8] = 8'h66;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("col_ready_wait", 32'(req_ready), 0);
        check("col_dv_wait", 32'(tx_dv), 0);
        check("col_busy_idle", 32'(busy), 0);
        tick();
        check("col2_ready", 32'(req_ready), 32'h2);
        check("col2_grant", 32'(grant_id), 1);
        req_valid = '0;
        req_data[15:8] = 8'h00;
        tick();
        check("col2_dv", 32'(tx_dv), 1);
        check("col2_byte", 32'(tx_byte), 32'h66);
        serve(5, 8'h66, "col2");

        // Reset in the middle of a frame (pointer at 2).
        req_data  = {8'hD3, 8'h00, 8'hD1, 8'h00};
        req_valid = 4'b1010;
        wait_dv("rst1");
        check("rst1_grant", 32'(grant_id), 3);
        check("rst1_byte", 32'(tx_byte), 32'hD3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_dv", 32'(tx_dv), 0);
        check("mid_rst_byte", 32'(tx_byte), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_grant", 32'(grant_id), 0);
        tick();
        check("rst2_ready", 32'(req_ready), 32'h2);
        check("rst2_grant", 32'(grant_id), 1);
        req_valid = '0;
        wait_dv("rst2");
        check("rst2_byte", 32'(tx_byte), 32'hD1);
        serve(5, 8'hD1, "rst2");

        // Packet of three bytes from requester 0, requester 1 always pending.
`ifdef UART_SCHED_PKT_LOCK_EN
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd1};
        exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hB1};
`else
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp_b = '{8'hA0, 8'hB1, 8'hA1, 8'hB1};
`endif
        cnt0 = 0;
        req_data  = {16'h0000, 8'hB1, 8'hA0};
        req_last  = 4'b0010;
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            wait_dv("pkt");
            check("pkt_grant", 32'(grant_id), 32'(exp_g[k]));
            check("pkt_byte", 32'(tx_byte), 32'(exp_b[k]));
            if (grant_id == 2'd0) begin
                cnt0++;
                if (cnt0 == 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_data[7:0] = 8'(8'hA0 + cnt0);
                    req_last[0]   = (cnt0 == 2);
                end
            end
            if (k == 3) req_valid = '0;
            serve(20, exp_b[k], "pkt");
        end
        req_last = '0;

        // Inter-frame gap on the GAP_CYCLES=5 instance.
        req_data_g  = {16'h0000, 8'hC1, 8'hC0};
        req_valid_g = 4'b0011;
        dv_at = 0;
        while (tx_dv_g !== 1'b1 && dv_at < 100) begin
            tick();
            dv_at++;
        end
        check("gap1_dv_seen", 32'(tx_dv_g), 1);
        check("gap1_byte", 32'(tx_byte_g), 32'hC0);
        check("gap1_grant", 32'(grant_id_g), 0);
        repeat (3) tick();
        tx_done_g = 1'b1;
        tick();
        tx_done_g = 1'b0;
        check("gap_busy_in_gap", 32'(busy_g), 1);
        first_idle = -1;
        dv_at = -1;
        for (int k = 1; k <= 20 && dv_at < 0; k++) begin
            tick();
            if (!busy_g && first_idle < 0) first_idle = k;
            if (tx_dv_g) dv_at = k;
        end
        check("gap_len", first_idle, 5);
        check("gap_dv_spacing", dv_at, 7);
        check("gap2_byte", 32'(tx_byte_g), 32'hC1);
        check("gap2_grant", 32'(grant_id_g), 1);
        req_valid_g = '0;
        repeat (3) tick();
        tx_done_g = 1'b1;
        tick();
        tx_done_g = 1'b0;
        repeat (8) tick();
        check("gap_final_idle", 32'(busy_g), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
